mux_n_rr_reg: RTL and testbench
===============================

Name: mux_n_rr_reg

Overview:
- Parametrised N-input, W-bit registered multiplexer. It is the successor of the 2-input 4-bit combinational mux.
- Adds a registered output, valid/ready handshakes on every input channel and on the output, and two selection modes:
  - mode 0: direct select, where the selected channel passes to the output.
  - mode 1: round-robin, which scans all valid channels fairly.
- Sits between several producers and a single consumer, for example to merge data sources into one bus.

Parameters:
- W, default 4, data width of each channel and of Out.
- N, default 4, number of input channels (N >= 2).
- SW, default 2, select width; must satisfy 2**SW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low. All registers clear immediately on assertion.
- In  input  N*W  packed channel data; channel i occupies In[i*W +: W].
- in_valid  input  N  channel i presents data.
- in_ready  output  N  channel i is accepted this cycle.
- s  input  SW  channel select, used in mode 0 only.
- mode  input  1  0 = direct select, 1 = round-robin.
- Out  output  W  registered data.
- out_valid  output  1  Out holds valid data.
- out_ready  input  1  consumer accepts Out.
- chan  output  SW  index of the channel that produced the current Out.

Behaviour:
- Reset values: Out=0, out_valid=0, chan=0. Internal round-robin pointer ptr=N-1, so the first round-robin search starts at channel 0. While reset_n=0, in_ready=0.
- Load condition: load = !out_valid || out_ready. The output register may take new data only when load=1.
- Grant, mode 0:
  - Granted channel is g=s, granted only if s<N and in_valid[s]=1.
  - If s>=N, there is no grant; the block never indexes out of range.
- Grant, mode 1:
  - g is the first channel with in_valid=1, searching ptr+1, ptr+2, ... and wrapping modulo N.
  - If no channel is valid, there is no grant.
- in_ready[i] = load && grant && (g==i). At most one in_ready bit is high per cycle.
  - in_ready is combinational from in_valid, s and mode. Producers must not make in_valid depend on in_ready.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At the next rising edge:
  - Out <= In[i*W +: W];
  - chan <= i;
  - out_valid <= 1;
  - ptr <= i. ptr updates in both modes, so switching to mode 1 continues fairly from the last granted channel.
- If load=1 and there is no grant: out_valid <= 0. Out and chan hold their old values and ptr holds.
- If load=0 (out_valid=1, out_ready=0): Out, chan, out_valid and ptr hold, all in_ready=0, and no data is lost.
- Latency and throughput:
  - Latency is 1 cycle from the input transfer to out_valid.
  - Throughput is 1 word per cycle while out_ready=1.
- Simultaneous output drain and new grant in the same cycle: the new data replaces the old and out_valid stays 1. There is no bubble.
- Changes to mode or s while Out is stalled have no effect until load=1. The held data never changes.
- Reset asserted mid-transfer: the registers clear asynchronously and the word in flight is dropped. After release, ptr=N-1 again.
- No arithmetic beyond the modulo-N wrap of the pointer. All index comparisons are SW bits wide.

Test Plan:
- Reset: with reset_n=0 and in_valid=4'b1111, require Out=0, out_valid=0, chan=0 and in_ready=0. After release with mode=1, the first grant goes to channel 0.
- Mode 0 direct select: N=4, W=4, In={4'hD,4'hC,4'hB,4'hA}, in_valid=4'b1111, s=2, out_ready=1.
  - Require in_ready=4'b0100.
  - Next cycle: Out=4'hC, chan=2, out_valid=1.
  - Then set s=1: next cycle Out=4'hB, chan=1.
- Mode 0, unselected source idle: s=3 with in_valid=4'b0111 gives in_ready=0. out_valid falls to 0 one cycle after drain.
- Round-robin fairness: mode=1, in_valid=4'b1011, out_ready=1 held.
  - Grants run in the order 0,1,3,0,1,3. chan follows the same sequence, and each channel's data appears on Out one cycle after its grant.
- Backpressure: out_valid=1 with Out=4'h5. Hold out_ready=0 for 3 cycles while changing In, s and mode.
  - Require Out=4'h5, chan unchanged and in_ready=0 throughout.
  - Raise out_ready: the new word loads in the same cycle with no bubble, and out_valid stays 1.
- Reset mid-stream: in mode 1, assert reset_n=0 between clock edges. Outputs clear immediately. After release with in_valid=4'b1000, the grant goes to channel 3 and the next Out is In[15:12].

Source files
------------

// File: rtl/mux_n_rr_reg.sv
// N-input, W-bit registered multiplexer with valid/ready handshakes on every
// channel and on the output. Mode 0 forwards the channel chosen by s; mode 1
// serves valid channels round-robin, starting after the last granted one.
module mux_n_rr_reg #(
    parameter int unsigned W  = 4,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N*W-1:0]      In,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [SW-1:0]       s,
    input  logic                mode,
    output logic [W-1:0]        Out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SW-1:0]       chan
);

    // Last granted channel; the round-robin search begins just after it.
    logic [SW-1:0] ptr;

    logic          load;
    logic          grant;
    logic [SW-1:0] g;
    logic [W-1:0]  g_data;

    // The output register may accept a word when empty or being drained.
    always_comb begin
        load = !out_valid || out_ready;
    end

    // Grant selection. Direct select only matches indices below N, so an
    // out-of-range s yields no grant. Round-robin is split into two ordered
    // passes (channels above ptr, then channels up to ptr) which together
    // realise the modulo-N wrap without an adder.
    always_comb begin
        grant  = 1'b0;
        g      = '0;
        g_data = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (s == SW'(i) && in_valid[i]) begin
                    grant  = 1'b1;
                    g      = SW'(i);
                    g_data = In[i*W +: W];
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant && SW'(i) > ptr && in_valid[i]) begin
                    grant  = 1'b1;
                    g      = SW'(i);
                    g_data = In[i*W +: W];
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant && SW'(i) <= ptr && in_valid[i]) begin
                    grant  = 1'b1;
                    g      = SW'(i);
                    g_data = In[i*W +: W];
                end
            end
        end
    end

    // One-hot ready to the granted channel; silenced while reset is held.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = reset_n && load && grant && (g == SW'(i));
        end
    end

    // Output register and round-robin pointer. With no grant the register
    // empties but keeps its last data and channel for observation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Out       <= '0;
            out_valid <= 1'b0;
            chan      <= '0;
            ptr       <= SW'(N - 1);
        end else if (load) begin
            if (grant) begin
                Out       <= g_data;
                chan      <= g;
                out_valid <= 1'b1;
                ptr       <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_rr_reg.sv
// Directed self-checking bench for mux_n_rr_reg with the default geometry
// (N=4, W=4, SW=2). Each task drives one scenario and checks it inline.
module tb_mux_n_rr_reg;

    localparam int unsigned W  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic            clk;
    logic            reset_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   s;
    logic            mode;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   chan;

    int errors = 0;
    int checks = 0;

    mux_n_rr_reg #(.W(W), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .In        (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .mode      (mode),
        .Out       (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .chan      (chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_data   = 16'hDCBA;
        in_valid  = 4'b1111;
        s         = 2'd0;
        mode      = 1'b1;
        out_ready = 1'b1;
        #12;
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out: got %h expected %h", out_data, 4'h0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0); end
        checks++; if (chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected %0d", chan, 0); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected %b", in_ready, 4'b0000); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected %b", in_ready, 4'b0001); end
        tick();
        checks++; if (out_data !== 4'hA || chan !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_word: got Out=%h chan=%0d ov=%b expected Out=a chan=0 ov=1", out_data, chan, out_valid);
        end
    endtask

    task automatic test_mode0();
        mode      = 1'b0;
        s         = 2'd2;
        in_data   = 16'hDCBA;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL mode0_ready_s2: got %b expected %b", in_ready, 4'b0100); end
        tick();
        checks++; if (out_data !== 4'hC || chan !== 2'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mode0_word_s2: got Out=%h chan=%0d ov=%b expected Out=c chan=2 ov=1", out_data, chan, out_valid);
        end
        s = 2'd1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL mode0_ready_s1: got %b expected %b", in_ready, 4'b0010); end
        tick();
        checks++; if (out_data !== 4'hB || chan !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mode0_word_s1: got Out=%h chan=%0d ov=%b expected Out=b chan=1 ov=1", out_data, chan, out_valid);
        end
    endtask

    task automatic test_idle_select();
        s        = 2'd3;
        in_valid = 4'b0111;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b expected %b", in_ready, 4'b0000); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_drain: got %b expected %b", out_valid, 1'b0); end
        checks++; if (out_data !== 4'hB || chan !== 2'd1) begin
            errors++; $display("FAIL idle_hold: got Out=%h chan=%0d expected Out=b chan=1", out_data, chan);
        end
    endtask

    task automatic test_round_robin();
        int unsigned exp_g[6]   = '{0, 1, 3, 0, 1, 3};
        logic [3:0]  exp_d[6]   = '{4'hA, 4'hB, 4'hD, 4'hA, 4'hB, 4'hD};
        logic [3:0]  exp_rdy[6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        // Park the pointer on channel 3 via a direct-select transfer.
        mode     = 1'b0;
        s        = 2'd3;
        in_valid = 4'b1000;
        tick();
        checks++; if (out_data !== 4'hD || chan !== 2'd3) begin
            errors++; $display("FAIL rr_setup: got Out=%h chan=%0d expected Out=d chan=3", out_data, chan);
        end
        mode     = 1'b1;
        in_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            #0;
            checks++; if (in_ready !== exp_rdy[k]) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy[k]);
            end
            tick();
            checks++; if (chan !== SW'(exp_g[k]) || out_data !== exp_d[k] || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_word[%0d]: got Out=%h chan=%0d ov=%b expected Out=%h chan=%0d ov=1",
                                   k, out_data, chan, out_valid, exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode      = 1'b0;
        s         = 2'd0;
        in_data   = 16'hDCB5;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 4'h5 || chan !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_setup: got Out=%h chan=%0d ov=%b expected Out=5 chan=0 ov=1", out_data, chan, out_valid);
        end
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            in_data = 16'h1234 + 16'(k * 16'h1111);
            s       = 2'(k + 1);
            mode    = k[0];
            #1;
            checks++; if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", k, in_ready, 4'b0000);
            end
            tick();
            checks++; if (out_data !== 4'h5 || chan !== 2'd0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got Out=%h chan=%0d ov=%b expected Out=5 chan=0 ov=1", k, out_data, chan, out_valid);
            end
        end
        mode      = 1'b0;
        s         = 2'd2;
        in_data   = 16'h9876;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", in_ready, 4'b0100); end
        tick();
        checks++; if (out_data !== 4'h8 || chan !== 2'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_word: got Out=%h chan=%0d ov=%b expected Out=8 chan=2 ov=1", out_data, chan, out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        mode      = 1'b1;
        in_data   = 16'hDCBA;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        // Pointer was 2, so round-robin picks channel 3 next.
        checks++; if (out_data !== 4'hD || chan !== 2'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got Out=%h chan=%0d ov=%b expected Out=d chan=3 ov=1", out_data, chan, out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_data !== 4'h0 || chan !== 2'd0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_clear: got Out=%h chan=%0d ov=%b rdy=%b expected Out=0 chan=0 ov=0 rdy=0000",
                               out_data, chan, out_valid, in_ready);
        end
        in_valid = 4'b1000;
        #1;
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready: got %b expected %b", in_ready, 4'b1000); end
        tick();
        checks++; if (out_data !== 4'hD || chan !== 2'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_word: got Out=%h chan=%0d ov=%b expected Out=d chan=3 ov=1", out_data, chan, out_valid);
        end
        // Pointer reset check: all valid after a grant on 3 wraps to 0.
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_wrap: got %b expected %b", in_ready, 4'b0001); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_idle_select();
        test_round_robin();
        test_backpressure();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
